// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared widths, reset PC and the fetch-queue entry type for the MIPS pipeline.
package mips_pipe_pkg;

    localparam int XLEN = 32;
    localparam int IM_AW = 8;
    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; head output holds the last popped entry while empty.
module fetch_fifo
    import mips_pipe_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wdata,
    output entry_t                 rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    entry_t          last_q, last_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push_en, pop_en;

    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign pop_en  = pop & !flush & !empty;
    assign push_en = push & !flush & (!full | pop_en);
    assign count   = count_q;
    assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

    // Next pointers/occupancy; flush empties the queue but keeps the last popped entry visible.
    always_comb begin
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop_en);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push_en);
        count_d  = flush ? '0 : count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        last_d   = pop_en ? mem_q[rd_ptr_q] : last_q;
    end

    // Control state; reset makes every stored entry unreachable at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Entry storage; a full queue being popped may overwrite the slot it is reading this cycle.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC, IM address drive and prefetch queue feeding decode, with redirect flush.
module if_fetch_queue
    import mips_pipe_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                   clk,
    input  logic                   Reset,
    output logic [IM_AW-1:0]       ImAdress,
    input  logic [XLEN-1:0]        OpCode,
    input  logic                   PCSel,
    input  logic [XLEN-1:0]        PCIn,
    input  logic                   IDReady,
    output logic                   IDValid,
    output logic [XLEN-1:0]        IDInstr,
    output logic [XLEN-1:0]        IDPCPlus4,
    output logic [XLEN-1:0]        FetchPC,
    output logic [$clog2(DEPTH):0] Count
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, pc_plus4;
    logic            full, empty, push, pop;
    fetch_entry_t    wr_entry, head;

    assign pc_plus4  = fetch_pc_q + 32'd4;
    assign IDValid   = !empty & !PCSel;
    assign pop       = IDValid & IDReady;
    assign push      = !PCSel & (!full | pop);
    assign wr_entry  = '{pc_plus4: pc_plus4, instr: OpCode};
    assign IDInstr   = head.instr;
    assign IDPCPlus4 = head.pc_plus4;
    assign FetchPC   = fetch_pc_q;
    assign ImAdress  = fetch_pc_q[IM_AW+1:2];

    // Redirect wins (target word-aligned); otherwise advance only when an entry is accepted.
    always_comb begin
        fetch_pc_d = PCSel ? (PCIn & ~32'h3) : push ? pc_plus4 : fetch_pc_q;
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .flush (PCSel),
        .wdata (wr_entry),
        .rdata (head),
        .count (Count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction-fetch front end that sits directly upstream of the IF/ID register. It owns the fetch PC and drives the word address to the combinational instruction memory. Each fetched opcode, paired with its PC+4, is buffered in a small prefetch queue. Decode consumes the queue through a valid/ready handshake, so a decode stall no longer freezes the PC. A taken branch or jump resolved in MEM flushes the queue and redirects fetch.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronised externally.
- ImAdress  out  8  IM word address; equals FetchPC[9:2].
- OpCode  in  32  instruction returned combinationally by IM for ImAdress.
- PCSel  in  1  redirect request (taken branch or jump), sampled every cycle.
- PCIn  in  32  redirect target, valid when PCSel=1.
- IDReady  in  1  decode accepts IDInstr this cycle; 0 means stall.
- IDValid  out  1  IDInstr and IDPCPlus4 hold a valid entry.
- IDInstr  out  32  head-of-queue instruction.
- IDPCPlus4  out  32  PC+4 of the head instruction.
- FetchPC  out  32  current fetch PC, for debug.
- Count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- pop = IDValid & IDReady.
- push = !PCSel & ((Count < DEPTH) | pop).
- On push:
  - the entry {FetchPC+4, OpCode} is written at the tail;
  - FetchPC <= FetchPC+4, with 32-bit modular arithmetic (32'hFFFF_FFFC wraps to 0).
- IM address wraps naturally at 256 words through bits [9:2].
- Pop advances the head pointer. Simultaneous push and pop leaves Count unchanged, including when the queue is full.
- When full and not popping: no push, FetchPC holds, and OpCode is ignored.
- When empty, IDValid=0. IDInstr and IDPCPlus4 then hold the last popped values, or 0 after reset; decode must treat them as a bubble.
- Redirect (PCSel=1) has priority over everything else:
  - IDValid is forced to 0 in that cycle, so no pop can occur;
  - no push occurs;
  - at the clock edge, both pointers and Count clear and FetchPC <= {PCIn[31:2], 2'b00}. Misaligned targets are silently aligned.
- PCSel held high for several cycles keeps the queue empty and reloads FetchPC from PCIn every cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full and empty are decided by Count, not by pointer compare.

## Timing
- Reset values:
  - FetchPC = RESET_PC, so ImAdress = RESET_PC[9:2];
  - Count = 0 and IDValid = 0;
  - IDInstr = 0 and IDPCPlus4 = 0;
  - pointers = 0.
- Fetch-to-decode latency is 1 cycle. The opcode present in cycle N is pushed at edge N and appears at the head in N+1 if the queue was empty.
- First edge after Reset deasserts: the instruction at RESET_PC is pushed. IDValid=1 from the following cycle.
- Redirect latency, with PCSel high in cycle N:
  - FetchPC = target in N+1;
  - the target instruction is pushed at edge N+1;
  - IDValid=1 in N+2.
- IDValid, IDInstr and IDPCPlus4 come from registered queue storage. The only exception is IDValid's combinational gating by PCSel.
- Sustained throughput is one instruction per cycle while IDReady=1.
- Reset asserted mid-stream: state clears asynchronously. No partially written entry survives.

## Structure
- Shared package mips_pipe_pkg holds:
  - width constants XLEN=32, IM_AW=8;
  - default RESET_PC;
  - the fetch entry typedef {pc_plus4[31:0], instr[31:0]}.
- Sub-module fetch_fifo: a generic synchronous FIFO with a flush input. Parameters are DEPTH and the entry type. It provides push, pop, flush, head data, Count, full and empty.
- The top level contains only the fetch-PC register, the push/pop/redirect logic and the IM address drive.

## Test plan
- Reset then free run, with IM[0..3] = 8C01_0000, 0022_1820, AC03_0004, 1000_FFFF and IDReady=1. IDValid rises 1 cycle after reset release. IDInstr steps through the four opcodes on consecutive cycles, with IDPCPlus4 = 4, 8, C, 10.
- IDReady=0 from reset. Count climbs to 4 and stalls; FetchPC = 32'h10 and is held. Raising IDReady yields PCs +4..+10 in order with no gap, and the refill keeps Count at 4.
- Full queue, with IDReady=1 and the last free slot refilled in the same cycle. Count stays 4 and no entry is lost or duplicated (check the sequence continuity of IDPCPlus4).
- PCSel=1 with PCIn=32'h40 while Count=3. IDValid=0 in that cycle; Count=0 and FetchPC=32'h40 next cycle. IDPCPlus4=32'h44 two cycles after PCSel.
- Misaligned redirect PCIn=32'h43, then wrap with PCIn=32'hFFFF_FFFC. The first gives FetchPC=32'h40. The second pushes an entry with IDPCPlus4=0, after which FetchPC=0.
- Reset asserted asynchronously between edges with Count=2. Outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
